// File: rtl/obi_mem_arbiter_pkg.sv
// Shared types for the OBI memory arbiter.
//   req_id_e : identifies which core port issued a memory transaction
//   INSTR_BE : byte enables presented for instruction fetches (full word)
package obi_mem_arbiter_pkg;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

  localparam logic [3:0] INSTR_BE = 4'hF;

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of requester IDs for transactions accepted by the memory
// but not yet answered.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   push_i, id_i    : store id_i (ignored when full)
//   pop_i           : drop the head entry (ignored when empty)
//   head_o          : oldest stored ID
//   full_o, empty_o : occupancy flags
//   count_o         : number of stored entries
module obi_arb_id_fifo
  import obi_mem_arbiter_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  req_id_e       id_i,
  input  logic          pop_i,
  output req_id_e       head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_id_e         mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= id_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Shares one OBI single-port memory between the instruction fetch and data
// ports of a core. Round-robin (or data-priority) arbitration, a request
// lock that keeps an ungranted request stable, and in-order routing of
// responses back to the port that issued them.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   instr_*           : instruction fetch master port (read only)
//   data_*            : data master port
//   mem_*             : memory slave port
//   outstanding_o     : transactions granted but not yet answered
//   err_o             : sticky, response seen with nothing outstanding
module obi_mem_arbiter
  import obi_mem_arbiter_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH      = 32,
  parameter  int unsigned MAX_OUTSTANDING = 2,
  parameter  int unsigned DATA_PRIORITY   = 0,
  localparam int unsigned CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  instr_req_i,
  output logic                  instr_gnt_o,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic [CW-1:0]         outstanding_o,
  output logic                  err_o
);

  req_id_e winner;
  logic    winner_req, grant, resp_valid;
  logic    fifo_full, fifo_empty;
  req_id_e fifo_head;

  logic    lock_q, lock_d;
  req_id_e lock_id_q, lock_id_d;
  req_id_e last_grant_q, last_grant_d;
  logic    err_q, err_d;

  always_comb begin
    winner = REQ_INSTR;
    if (lock_q) begin
      winner = lock_id_q;
    end else if (instr_req_i && data_req_i) begin
      if (DATA_PRIORITY != 0) winner = REQ_DATA;
      else winner = (last_grant_q == REQ_DATA) ? REQ_INSTR : REQ_DATA;
    end else if (data_req_i) begin
      winner = REQ_DATA;
    end
  end

  assign winner_req  = (winner == REQ_DATA) ? data_req_i : instr_req_i;
  // A full ID FIFO blocks new requests even if a response pops this cycle.
  assign mem_req_o   = winner_req & ~fifo_full & ~rst_i;
  assign grant       = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = grant & (winner == REQ_INSTR);
  assign data_gnt_o  = grant & (winner == REQ_DATA);

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_wdata_o = 32'h0;
    if (mem_req_o) begin
      if (winner == REQ_DATA) begin
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_addr_o  = instr_addr_i;
        mem_be_o    = INSTR_BE;
      end
    end
  end

  assign resp_valid     = mem_rvalid_i & ~fifo_empty & ~rst_i;
  assign instr_rvalid_o = resp_valid & (fifo_head == REQ_INSTR);
  assign data_rvalid_o  = resp_valid & (fifo_head == REQ_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign err_o          = err_q;

  always_comb begin
    lock_d       = lock_q;
    lock_id_d    = lock_id_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    if (grant) begin
      last_grant_d = winner;
      lock_d       = 1'b0;
    end else if (mem_req_o) begin
      // Ungranted request must stay presented until the memory takes it.
      lock_d    = 1'b1;
      lock_id_d = winner;
    end
    if (mem_rvalid_i && fifo_empty) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q       <= 1'b0;
      lock_id_q    <= REQ_INSTR;
      last_grant_q <= REQ_DATA;
      err_q        <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_id_q    <= lock_id_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (grant),
    .id_i    (winner),
    .pop_i   (resp_valid),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

endmodule

// File: doc/obi_mem_arbiter.md
Name: obi_mem_arbiter

Overview:
- Shares one OBI-style single-port memory slave between the core instruction fetch port and the core data port. The memory slave uses req/gnt/rvalid handshakes.
- Sits between the core and the RAM/pseudo-peripheral model in the core testbench, so a single-ported memory can serve both masters.
- Arbitrates round-robin and tracks outstanding transactions in order. Each response is routed back to the requester that issued it.

Parameters:
ADDR_WIDTH, 32, address width of all three ports
MAX_OUTSTANDING, 2, depth of the in-order requester-ID FIFO (≥1)
DATA_PRIORITY, 0, 1 = data port always wins on conflict; 0 = round-robin

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous reset, active-high
instr_req_i  in  1  instruction fetch request
instr_gnt_o  out  1  fetch request accepted
instr_addr_i  in  ADDR_WIDTH  fetch address
instr_rvalid_o  out  1  fetch response valid
instr_rdata_o  out  32  fetch response data
data_req_i  in  1  data request
data_gnt_o  out  1  data request accepted
data_addr_i  in  ADDR_WIDTH  data address
data_we_i  in  1  write enable
data_be_i  in  4  byte enables
data_wdata_i  in  32  write data
data_rvalid_o  out  1  data response valid
data_rdata_o  out  32  data read data
mem_req_o  out  1  request to memory
mem_gnt_i  in  1  memory accepted request
mem_addr_o  out  ADDR_WIDTH  address to memory
mem_we_o  out  1  write enable to memory
mem_be_o  out  4  byte enables to memory
mem_wdata_o  out  32  write data to memory
mem_rvalid_i  in  1  memory response valid (in order)
mem_rdata_i  in  32  memory response data
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current FIFO occupancy
err_o  out  1  sticky: mem_rvalid_i received with no outstanding transaction

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous, active-high.
- Reset values:
  - Registered state: lock = 0, last_grant = DATA (so instr wins the first conflict), FIFO empty, err_o = 0, outstanding_o = 0.
  - mem_req_o, both gnt outputs and both rvalid outputs are forced 0 while rst_i = 1.
- Winner selection (combinational):
  - If lock = 1, the winner is the locked ID.
  - Otherwise, with a single requester, that requester wins.
  - With both requesting: DATA if DATA_PRIORITY = 1, else the requester not equal to last_grant.
- Request forwarding:
  - mem_req_o = winner's req AND FIFO not full.
  - No push/pop bypass: a full FIFO blocks mem_req_o even if mem_rvalid_i is high that cycle.
  - mem_addr/we/be/wdata are muxed from the winner. The instr path drives we = 0, be = 4'hF, wdata = 0. All are 0 when mem_req_o = 0.
- Grant:
  - winner_gnt_o = mem_req_o AND mem_gnt_i, combinational, zero added latency. The loser's gnt_o = 0.
  - On grant: push winner ID, last_grant <= winner, lock <= 0.
- Lock (OBI stability rule):
  - If mem_req_o = 1 and mem_gnt_i = 0, lock <= 1 with the locked ID = winner.
  - The other requester cannot win until the locked request is granted.
- Response routing:
  - On mem_rvalid_i, pop the FIFO head. Head = INSTR asserts instr_rvalid_o; head = DATA asserts data_rvalid_o. Same cycle, combinational.
  - instr_rdata_o and data_rdata_o are both driven directly from mem_rdata_i; they are qualified only by their rvalid.
- Simultaneous grant (push) and rvalid (pop): occupancy is unchanged and both take effect.
- mem_rvalid_i with the FIFO empty: no rvalid is forwarded and err_o <= 1, held until reset.
- Reset mid-operation: outstanding entries are discarded and the lock is cleared. The memory is reset by the same rst_i, so stale responses are not expected; if one arrives, err_o is set.
- Latency: request 0 cycles added, response 0 cycles added. Back-to-back grants are allowed every cycle up to MAX_OUTSTANDING in flight.

Decomposition:
- Package obi_mem_arbiter_pkg:
  - typedef enum logic {REQ_INSTR = 1'b0, REQ_DATA = 1'b1} req_id_e
  - localparam INSTR_BE = 4'hF
- Sub-module obi_arb_id_fifo:
  - Parameterised depth, storing req_id_e.
  - Push/pop with full, empty and count outputs; synchronous active-high reset.

Test Plan:
1. Reset release, only instr_req_i = 1, addr 0x80, mem_gnt_i = 1, rvalid one cycle later with rdata 0x00000013 -> instr_gnt_o = 1 in the request cycle; instr_rvalid_o = 1 with instr_rdata_o = 0x13 next cycle; data_rvalid_o = 0.
2. Both requesting every cycle, mem_gnt_i = 1, DATA_PRIORITY = 0 -> grants alternate INSTR, DATA, INSTR, DATA. Responses route in the same order; outstanding_o never exceeds 2.
3. Data write addr 0x1000_0000, wdata 0xDEADBEEF, be 4'b0011, mem_gnt_i held 0 for 3 cycles while instr_req_i rises -> mem_* stays on the data request for all 3 cycles. Data is granted on cycle 4; instr is granted on the next cycle.
4. MAX_OUTSTANDING = 2, two grants, no rvalid -> mem_req_o = 0 and outstanding_o = 2. An rvalid in cycle N (with req still high) -> mem_req_o = 1 only in cycle N+1.
5. Spurious mem_rvalid_i with the FIFO empty -> neither rvalid asserts and err_o = 1 from the next cycle until rst_i.
6. rst_i asserted with 2 outstanding and lock set -> next cycle outstanding_o = 0, all gnt/rvalid/req outputs 0, and instr wins the first post-reset conflict.
